// File: rtl/video_src_gen.sv
// Raster test-pattern source for the scaler input port; outputs lag the counters by 1 cycle.
// Free-running once started (no backpressure); en=0 finishes the current frame before idling.
module video_src_gen #(
  parameter int DATA_WIDTH      = 16,
  parameter int INPUT_RES_WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [INPUT_RES_WIDTH-1:0] xRes,
  input  logic [INPUT_RES_WIDTH-1:0] yRes,
  input  logic [INPUT_RES_WIDTH-1:0] hBlank,
  input  logic [INPUT_RES_WIDTH-1:0] vBlank,
  input  logic [1:0]                 patSel,
  output logic [DATA_WIDTH-1:0]      dOut,
  output logic                       dOutEn,
  output logic                       HS,
  output logic                       VS,
  output logic                       frameDone
);

  localparam int RW = INPUT_RES_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   hcnt_q, hcnt_d;
  logic [RW-1:0]   vcnt_q, vcnt_d;
  logic [RW-1:0]   xres_q, xres_d;
  logic [RW-1:0]   yres_q, yres_d;
  logic [RW-1:0]   hb_q, hb_d;
  logic [RW-1:0]   vb_q, vb_d;
  logic [1:0]      pat_q, pat_d;
  logic [DW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_en_q, dout_en_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            frame_done_q, frame_done_d;

  logic            size_ok;
  logic [RW-1:0]   hb_in, vb_in;
  logic [RW:0]     h_end, v_end;
  logic            h_last, v_last, frame_end;
  logic            counting, active;
  logic [DW-1:0]   pix;

  // Blanking of zero is promoted to one so HS/VS always get at least one cycle/line.
  always_comb begin
    size_ok  = (xRes != '0) && (yRes != '0);
    hb_in    = (hBlank == '0) ? RW'(1) : hBlank;
    vb_in    = (vBlank == '0) ? RW'(1) : vBlank;
    h_end    = {1'b0, xres_q} + {1'b0, hb_q} - (RW+1)'(1);
    v_end    = {1'b0, yres_q} + {1'b0, vb_q} - (RW+1)'(1);
    h_last   = ({1'b0, hcnt_q} == h_end);
    v_last   = ({1'b0, vcnt_q} == v_end);
    frame_end = h_last && v_last;
    counting = (state_q != S_IDLE);
    active   = counting && (hcnt_q < xres_q) && (vcnt_q < yres_q);
  end

  always_comb begin
    pix = '0;
    case (pat_q)
      2'd0:    pix = DW'(hcnt_q);
      2'd1:    pix = DW'(vcnt_q);
      2'd2:    pix = (hcnt_q[3] ^ vcnt_q[3]) ? {DW{1'b1}} : '0;
      default: pix = frame_cnt_q;
    endcase
  end

  always_comb begin
    dout_d       = active ? pix : '0;
    dout_en_d    = active;
    hs_d         = counting && (hcnt_q >= xres_q);
    vs_d         = counting && (vcnt_q >= yres_q);
    frame_done_d = counting && frame_end;
  end

  // Sequencing: shadows only load on entry from IDLE and at frame boundaries.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    xres_d      = xres_q;
    yres_d      = yres_q;
    hb_d        = hb_q;
    vb_d        = vb_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en && size_ok) begin
          xres_d  = xRes;
          yres_d  = yRes;
          hb_d    = hb_in;
          vb_d    = vb_in;
          pat_d   = patSel;
          state_d = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        state_d = en ? S_RUN : S_DRAIN;
        if (frame_end) begin
          hcnt_d      = '0;
          vcnt_d      = '0;
          frame_cnt_d = frame_cnt_q + DW'(1);
          if (en && size_ok) begin
            xres_d  = xRes;
            yres_d  = yRes;
            hb_d    = hb_in;
            vb_d    = vb_in;
            pat_d   = patSel;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end else if (h_last) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + RW'(1);
        end else begin
          hcnt_d = hcnt_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      xres_q       <= '0;
      yres_q       <= '0;
      hb_q         <= '0;
      vb_q         <= '0;
      pat_q        <= '0;
      frame_cnt_q  <= '0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      xres_q       <= xres_d;
      yres_q       <= yres_d;
      hb_q         <= hb_d;
      vb_q         <= vb_d;
      pat_q        <= pat_d;
      frame_cnt_q  <= frame_cnt_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dOut      = dout_q;
  assign dOutEn    = dout_en_q;
  assign HS        = hs_q;
  assign VS        = vs_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_video_src_gen.sv
// Bench for video_src_gen: expected pixels and per-frame statistics are queued by the
// stimulus process and consumed by a negedge monitor.
module tb_video_src_gen;
  localparam int DW = 16;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [RW-1:0] xRes = '0, yRes = '0, hBlank = '0, vBlank = '0;
  logic [1:0]    patSel = '0;
  logic [DW-1:0] dOut;
  logic          dOutEn, HS, VS, frameDone;

  video_src_gen #(.DATA_WIDTH(DW), .INPUT_RES_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .xRes(xRes), .yRes(yRes), .hBlank(hBlank), .vBlank(vBlank), .patSel(patSel),
    .dOut(dOut), .dOutEn(dOutEn), .HS(HS), .VS(VS), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;   // 0: previous frameDone unknown, skip the period check
    int ens;
    int hss;
    int vss;
  } frm_t;

  logic [DW-1:0] exp_pix[$];
  frm_t          exp_frm[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc_since = 0, n_en = 0, n_hs = 0, n_vs = 0, en_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    frm_t          f;
    if (!rst) begin
      cyc_since = 0; n_en = 0; n_hs = 0; n_vs = 0;
    end else begin
      cyc_since++;
      if (dOutEn) begin
        n_en++;
        en_total++;
        if (exp_pix.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: got dOut=0x%0h, expected no pixel", dOut);
        end else begin
          e = exp_pix.pop_front();
          check("pixel{dOut,HS,VS}", {dOut, HS, VS}, {e, 2'b00});
        end
      end else begin
        check("blank_dout_zero", dOut, 0);
      end
      if (HS) n_hs++;
      if (VS) n_vs++;
      if (frameDone) begin
        if (exp_frm.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frameDone: got pulse, expected none");
        end else begin
          f = exp_frm.pop_front();
          check("frame_en_cycles", n_en, f.ens);
          check("frame_hs_cycles", n_hs, f.hss);
          check("frame_vs_cycles", n_vs, f.vss);
          if (f.len != 0) check("frame_period", cyc_since, f.len);
        end
        cyc_since = 0; n_en = 0; n_hs = 0; n_vs = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en  = 1'b0;
    cycles(3);
    rst = 1'b1;
  endtask

  task automatic cfg(input int x, input int y, input int hb, input int vb, input int p);
    xRes = RW'(x); yRes = RW'(y); hBlank = RW'(hb); vBlank = RW'(vb); patSel = 2'(p);
  endtask

  task automatic push_frame(input int x, input int y, input int p, input int fnum);
    for (int v = 0; v < y; v++)
      for (int h = 0; h < x; h++)
        case (p)
          0:       exp_pix.push_back(DW'(h));
          1:       exp_pix.push_back(DW'(v));
          2:       exp_pix.push_back(((h ^ v) & 8) != 0 ? 16'hFFFF : 16'h0000);
          default: exp_pix.push_back(DW'(fnum));
        endcase
  endtask

  task automatic push_rec(input int len, input int ens, input int hss, input int vss);
    exp_frm.push_back('{len, ens, hss, vss});
  endtask

  task automatic wait_fd(input string name, input int bound);
    int k = 0;
    @(negedge clk); #1;
    while (!frameDone && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_frameDone"}, frameDone, 1);
  endtask

  task automatic check_low(input string name);
    check(name, {dOut, dOutEn, HS, VS, frameDone}, 0);
  endtask

  task automatic drained(input string name);
    check({name, "_pixels_left"}, exp_pix.size(), 0);
    check({name, "_frames_left"}, exp_frm.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int snap;
    #23;
    check_low("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(2);
    check_low("idle_after_reset");

    // Basic raster 4x3, blank 2/2, horizontal ramp
    cfg(4, 3, 2, 2, 0);
    push_frame(4, 3, 0, 0);
    push_frame(4, 3, 0, 1);
    push_rec(0, 12, 10, 12);
    push_rec(30, 12, 10, 12);
    en = 1'b1;
    @(posedge clk); #1;
    check("start_k_dOutEn", dOutEn, 0);
    @(posedge clk); #1;
    check("start_k1_{en,dOut}", {dOutEn, dOut}, {1'b1, 16'h0000});
    wait_fd("t1_f0", 100);
    wait_fd("t1_f1", 100);
    apply_reset();
    drained("t1");

    // Zero blanking forced to one
    cfg(2, 2, 0, 0, 0);
    push_frame(2, 2, 0, 0);
    push_frame(2, 2, 0, 1);
    push_rec(0, 4, 3, 3);
    push_rec(9, 4, 3, 3);
    en = 1'b1;
    wait_fd("t2_f0", 50);
    wait_fd("t2_f1", 50);
    apply_reset();
    drained("t2");

    // Drain: drop en mid frame 1, frame completes then outputs low
    cfg(4, 3, 2, 2, 1);
    push_frame(4, 3, 1, 0);
    push_frame(4, 3, 1, 1);
    push_rec(0, 12, 10, 12);
    push_rec(30, 12, 10, 12);
    en = 1'b1;
    wait_fd("t3_f0", 100);
    cycles(10);
    en = 1'b0;
    wait_fd("t3_drain", 100);
    @(posedge clk); #1;
    check_low("t3_low_after_drain");
    cycles(20);
    check_low("t3_still_idle");
    drained("t3a");

    // Re-assert en during DRAIN: next frame follows with no gap
    push_frame(4, 3, 1, 0);
    push_frame(4, 3, 1, 1);
    push_rec(0, 12, 10, 12);
    push_rec(30, 12, 10, 12);
    en = 1'b1;
    cycles(10);
    en = 1'b0;
    cycles(5);
    en = 1'b1;
    wait_fd("t3b_f0", 100);
    wait_fd("t3b_f1", 100);
    apply_reset();
    drained("t3b");

    // xRes change mid-frame takes effect at the next frame
    cfg(4, 3, 2, 2, 0);
    push_frame(4, 3, 0, 0);
    push_frame(6, 3, 0, 1);
    push_rec(0, 12, 10, 12);
    push_rec(40, 18, 10, 16);
    en = 1'b1;
    cycles(10);
    xRes = RW'(6);
    wait_fd("t4_f0", 100);
    wait_fd("t4_f1", 100);
    apply_reset();
    drained("t4");

    // Checkerboard 16x16
    cfg(16, 16, 2, 2, 2);
    push_frame(16, 16, 2, 0);
    push_rec(0, 256, 36, 36);
    en = 1'b1;
    cycles(50);
    en = 1'b0;
    wait_fd("t5_checker", 400);
    @(posedge clk); #1;
    check_low("t5_checker_low");
    drained("t5a");

    // Flat field carries the frame counter
    apply_reset();
    cfg(2, 2, 1, 1, 3);
    for (int f = 0; f < 3; f++) push_frame(2, 2, 3, f);
    push_rec(0, 4, 3, 3);
    push_rec(9, 4, 3, 3);
    push_rec(9, 4, 3, 3);
    en = 1'b1;
    wait_fd("t5_flat_f0", 50);
    wait_fd("t5_flat_f1", 50);
    en = 1'b0;
    wait_fd("t5_flat_f2", 50);
    @(posedge clk); #1;
    check_low("t5_flat_low");
    drained("t5b");

    // Async reset mid-line, then illegal sizes
    apply_reset();
    cfg(4, 3, 2, 2, 0);
    push_frame(4, 3, 0, 0);
    en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_mid_line_{en,dOut}", {dOutEn, dOut}, {1'b1, 16'h0001});
    #2;
    rst = 1'b0;
    #1;
    check_low("t6_async_reset");
    exp_pix.delete();
    exp_frm.delete();
    en = 1'b0;
    cycles(2);
    rst = 1'b1;
    cfg(0, 3, 2, 2, 0);
    snap = en_total;
    en = 1'b1;
    cycles(60);
    check("t6_xres0_no_pixels", en_total - snap, 0);
    check_low("t6_xres0_low");
    cfg(4, 0, 2, 2, 0);
    snap = en_total;
    cycles(40);
    check("t6_yres0_no_pixels", en_total - snap, 0);
    check_low("t6_yres0_low");
    en = 1'b0;
    drained("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
